// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback path.
package regfile_pkg;

  localparam int N_REGS_DEF  = 32;
  localparam int R_WIDTH_DEF = 32;
  localparam int W_ADDR_DEF  = $clog2(N_REGS_DEF);

  localparam logic [W_ADDR_DEF-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic [W_ADDR_DEF-1:0]  rd;
    logic [R_WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_sequencer_wb_fifo.sv
// Writeback buffer: circular FIFO of wb_entry_t accepting up to two pushes
// and one pop per cycle, with the occupancy exposed to the producer side.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_n,
  input  wb_entry_t                push0,
  input  wb_entry_t                push1,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   wr_ptr_p1;

  assign wr_ptr_p1 = wr_ptr_reg + PW'(1);
  assign head      = mem[rd_ptr_reg];
  assign count     = count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop);
      count_reg  <= count_reg + CW'(push_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem[wr_ptr_reg] <= push0;
    end
    if (push_n == 2'd2) begin
      mem[wr_ptr_p1] <= push1;
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Merges ALU and MEM writeback results onto the single register-file write
// port and tracks per-register pending writes for decode RAW checks.
module regfile_wb_sequencer
  import regfile_pkg::*;
#(
  parameter int N_REGS     = N_REGS_DEF,
  parameter int R_WIDTH    = R_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int W_ADDR    = $clog2(N_REGS),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [W_ADDR-1:0]  alu_rd,
  input  logic [R_WIDTH-1:0] alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [W_ADDR-1:0]  mem_rd,
  input  logic [R_WIDTH-1:0] mem_data,
  input  logic               issue_valid,
  input  logic [W_ADDR-1:0]  issue_rd,
  input  logic [W_ADDR-1:0]  chk_rs1_addr,
  input  logic [W_ADDR-1:0]  chk_rs2_addr,
  output logic               chk_rs1_busy,
  output logic               chk_rs2_busy,
  output logic               rf_write,
  output logic [W_ADDR-1:0]  rf_addr,
  output logic [R_WIDTH-1:0] rf_data,
  input  logic               rf_addr_error,
  output logic               issue_conflict,
  output logic               wb_error,
  output logic [CW-1:0]      wb_count
);

  wb_entry_t mem_entry, alu_entry, head_entry;
  wb_entry_t first_entry, second_entry, fifo_push0, fifo_push1, wr_entry_next;
  logic [1:0] n_acc, fifo_push_n;
  logic       ready, mem_push, alu_push, fifo_empty, bypass, fifo_pop, wr_valid_next;

  logic               rf_write_reg;
  logic [W_ADDR-1:0]  rf_addr_reg;
  logic [R_WIDTH-1:0] rf_data_reg;
  logic [N_REGS-1:0]  busy_reg, busy_next;
  logic               issue_set, conflict_set;
  logic               issue_conflict_reg, wb_error_reg;

  // Both sources gate on two free slots so a dual push can never overflow.
  assign ready      = (wb_count <= CW'(FIFO_DEPTH - 2));
  assign alu_ready  = ready;
  assign mem_ready  = ready;
  assign mem_push   = mem_valid && ready && (mem_rd != RF_ZERO_ADDR);
  assign alu_push   = alu_valid && ready && (alu_rd != RF_ZERO_ADDR);
  assign mem_entry  = '{rd: mem_rd, data: mem_data};
  assign alu_entry  = '{rd: alu_rd, data: alu_data};
  assign fifo_empty = (wb_count == '0);

  always_comb begin
    first_entry   = mem_entry;
    second_entry  = alu_entry;
    n_acc         = 2'd0;
    bypass        = 1'b0;
    fifo_push_n   = 2'd0;
    fifo_push0    = mem_entry;
    fifo_push1    = alu_entry;
    fifo_pop      = !fifo_empty;
    wr_valid_next = 1'b0;
    wr_entry_next = head_entry;
    if (mem_push) begin
      n_acc = alu_push ? 2'd2 : 2'd1;
    end else if (alu_push) begin
      first_entry = alu_entry;
      n_acc       = 2'd1;
    end
    // An empty buffer hands the oldest new result straight to the write port.
    bypass = fifo_empty && (n_acc != 2'd0);
    if (bypass) begin
      fifo_push_n   = n_acc - 2'd1;
      fifo_push0    = second_entry;
      wr_valid_next = 1'b1;
      wr_entry_next = first_entry;
    end else begin
      fifo_push_n   = n_acc;
      fifo_push0    = first_entry;
      fifo_push1    = second_entry;
      wr_valid_next = fifo_pop;
    end
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_n (fifo_push_n),
    .push0  (fifo_push0),
    .push1  (fifo_push1),
    .pop    (fifo_pop),
    .head   (head_entry),
    .count  (wb_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_reg <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
    end else begin
      rf_write_reg <= wr_valid_next;
      if (wr_valid_next) begin
        rf_addr_reg <= wr_entry_next.rd;
        rf_data_reg <= wr_entry_next.data;
      end
    end
  end

  assign rf_write = rf_write_reg;
  assign rf_addr  = rf_addr_reg;
  assign rf_data  = rf_data_reg;

  // A set and a clear landing on the same register in one edge leave it busy.
  assign issue_set = issue_valid && (issue_rd != RF_ZERO_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_busy
      assign busy_next[gi] = (gi != 0) &&
          ((issue_set && (issue_rd == W_ADDR'(gi))) ||
           (busy_reg[gi] && !(rf_write_reg && (rf_addr_reg == W_ADDR'(gi)))));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign conflict_set = issue_set && busy_reg[issue_rd] &&
                        !(rf_write_reg && (rf_addr_reg == issue_rd));

  assign chk_rs1_busy = busy_reg[chk_rs1_addr] && !(rf_write_reg && (rf_addr_reg == chk_rs1_addr));
  assign chk_rs2_busy = busy_reg[chk_rs2_addr] && !(rf_write_reg && (rf_addr_reg == chk_rs2_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_conflict_reg <= 1'b0;
      wb_error_reg       <= 1'b0;
    end else begin
      if (conflict_set) issue_conflict_reg <= 1'b1;
      if (rf_addr_error) wb_error_reg <= 1'b1;
    end
  end

  assign issue_conflict = issue_conflict_reg;
  assign wb_error       = wb_error_reg;

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed self-checking bench for regfile_wb_sequencer.
module tb_regfile_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd, chk_rs1_addr, chk_rs2_addr, rf_addr;
  logic [31:0] alu_data, mem_data, rf_data;
  logic        issue_valid, chk_rs1_busy, chk_rs2_busy, rf_write;
  logic        rf_addr_error, issue_conflict, wb_error;
  logic [2:0]  wb_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_wb_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .chk_rs1_addr   (chk_rs1_addr),
    .chk_rs2_addr   (chk_rs2_addr),
    .chk_rs1_busy   (chk_rs1_busy),
    .chk_rs2_busy   (chk_rs2_busy),
    .rf_write       (rf_write),
    .rf_addr        (rf_addr),
    .rf_data        (rf_data),
    .rf_addr_error  (rf_addr_error),
    .issue_conflict (issue_conflict),
    .wb_error       (wb_error),
    .wb_count       (wb_count)
  );

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rf_addr_error = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    chk_rs1_addr = '0; chk_rs2_addr = '0;
    tick(); tick();
    n_checks++; if (rf_write !== 1'b0) $display("FAIL reset_rf_write: got %0b want 0", rf_write); else n_pass++;
    n_checks++; if (rf_addr !== 5'd0) $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); else n_pass++;
    n_checks++; if (rf_data !== 32'd0) $display("FAIL reset_rf_data: got %h want 0", rf_data); else n_pass++;
    n_checks++; if (wb_count !== 3'd0) $display("FAIL reset_wb_count: got %0d want 0", wb_count); else n_pass++;
    n_checks++; if (issue_conflict !== 1'b0 || wb_error !== 1'b0) $display("FAIL reset_sticky: got %0b%0b want 00", issue_conflict, wb_error); else n_pass++;
    n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) $display("FAIL reset_ready: got %0b%0b want 11", alu_ready, mem_ready); else n_pass++;
    rst = 1'b0;
    tick();
    $display("reset: released");
  endtask

  task automatic test_reset_mid_traffic();
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + 2 * k); mem_data = 32'h100 + 32'(k);
      alu_valid = 1'b1; alu_rd = 5'(11 + 2 * k); alu_data = 32'h200 + 32'(k);
      tick();
    end
    idle();
    chk_rs1_addr = 5'd20;
    #1;
    n_checks++; if (wb_count !== 3'd3) $display("FAIL midrst_fill_count: got %0d want 3", wb_count); else n_pass++;
    n_checks++; if (chk_rs1_busy !== 1'b1) $display("FAIL midrst_busy_before: got %0b want 1", chk_rs1_busy); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (wb_count !== 3'd0) $display("FAIL midrst_count: got %0d want 0", wb_count); else n_pass++;
    n_checks++; if (rf_write !== 1'b0) $display("FAIL midrst_rf_write: got %0b want 0", rf_write); else n_pass++;
    n_checks++; if (chk_rs1_busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", chk_rs1_busy); else n_pass++;
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (rf_write !== 1'b0) $display("FAIL midrst_stale_write: cycle %0d got %0b want 0", k, rf_write); else n_pass++;
    end
    $display("reset_mid_traffic: done");
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    idle();
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEAD_BEEF)
      $display("FAIL single_write: got w=%0b a=%0d d=%h want w=1 a=5 d=deadbeef", rf_write, rf_addr, rf_data); else n_pass++;
    tick();
    n_checks++; if (rf_write !== 1'b0) $display("FAIL single_once: got %0b want 0", rf_write); else n_pass++;
    n_checks++; if (rf_addr !== 5'd5 || rf_data !== 32'hDEAD_BEEF)
      $display("FAIL single_hold: got a=%0d d=%h want a=5 d=deadbeef", rf_addr, rf_data); else n_pass++;
    $display("single_alu: done");
  endtask

  task automatic test_dual();
    logic [4:0] exp_addr [6];
    logic [2:0] exp_cnt [6];
    logic       exp_rdy [6];
    exp_addr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    tick();
    idle();
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h11)
      $display("FAIL dual_mem_first: got w=%0b a=%0d d=%h want w=1 a=3 d=11", rf_write, rf_addr, rf_data); else n_pass++;
    n_checks++; if (wb_count !== 3'd1) $display("FAIL dual_count: got %0d want 1", wb_count); else n_pass++;
    tick();
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h22)
      $display("FAIL dual_alu_second: got w=%0b a=%0d d=%h want w=1 a=4 d=22", rf_write, rf_addr, rf_data); else n_pass++;
    tick();
    n_checks++; if (rf_write !== 1'b0) $display("FAIL dual_idle: got %0b want 0", rf_write); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        mem_valid = 1'b1; mem_rd = 5'(10 + 2 * k); mem_data = 32'hA0 + 32'(10 + 2 * k);
        alu_valid = 1'b1; alu_rd = 5'(11 + 2 * k); alu_data = 32'hA0 + 32'(11 + 2 * k);
      end
      tick();
      idle();
      n_checks++; if (rf_write !== 1'b1 || rf_addr !== exp_addr[k] || rf_data !== 32'hA0 + 32'(exp_addr[k]))
        $display("FAIL fill_order: step %0d got w=%0b a=%0d d=%h want a=%0d", k, rf_write, rf_addr, rf_data, exp_addr[k]); else n_pass++;
      n_checks++; if (wb_count !== exp_cnt[k]) $display("FAIL fill_count: step %0d got %0d want %0d", k, wb_count, exp_cnt[k]); else n_pass++;
      n_checks++; if (alu_ready !== exp_rdy[k] || mem_ready !== exp_rdy[k])
        $display("FAIL fill_ready: step %0d got %0b%0b want %0b", k, alu_ready, mem_ready, exp_rdy[k]); else n_pass++;
    end
    $display("dual: done");
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    chk_rs1_addr = 5'd7; chk_rs2_addr = 5'd8;
    #1;
    n_checks++; if (chk_rs1_busy !== 1'b1) $display("FAIL sb_busy_set: got %0b want 1", chk_rs1_busy); else n_pass++;
    n_checks++; if (chk_rs2_busy !== 1'b0) $display("FAIL sb_other_clear: got %0b want 0", chk_rs2_busy); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    idle();
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd7) $display("FAIL sb_write7: got w=%0b a=%0d want w=1 a=7", rf_write, rf_addr); else n_pass++;
    n_checks++; if (chk_rs1_busy !== 1'b0) $display("FAIL sb_forward: got %0b want 0", chk_rs1_busy); else n_pass++;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    n_checks++; if (chk_rs1_busy !== 1'b1) $display("FAIL sb_set_wins: got %0b want 1", chk_rs1_busy); else n_pass++;
    n_checks++; if (issue_conflict !== 1'b0) $display("FAIL sb_no_conflict_on_clear: got %0b want 0", issue_conflict); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    tick();
    idle();
    tick();
    n_checks++; if (chk_rs1_busy !== 1'b0) $display("FAIL sb_cleared: got %0b want 0", chk_rs1_busy); else n_pass++;
    $display("scoreboard: done");
  endtask

  task automatic test_rd0_conflict();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    idle();
    n_checks++; if (rf_write !== 1'b0 || wb_count !== 3'd0)
      $display("FAIL rd0_dropped: got w=%0b cnt=%0d want w=0 cnt=0", rf_write, wb_count); else n_pass++;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    n_checks++; if (issue_conflict !== 1'b0) $display("FAIL conflict_first_issue: got %0b want 0", issue_conflict); else n_pass++;
    tick();
    idle();
    chk_rs1_addr = 5'd9;
    #1;
    n_checks++; if (issue_conflict !== 1'b1) $display("FAIL conflict_set: got %0b want 1", issue_conflict); else n_pass++;
    n_checks++; if (chk_rs1_busy !== 1'b1) $display("FAIL conflict_busy_kept: got %0b want 1", chk_rs1_busy); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    idle();
    tick();
    n_checks++; if (issue_conflict !== 1'b1) $display("FAIL conflict_sticky: got %0b want 1", issue_conflict); else n_pass++;
    n_checks++; if (chk_rs1_busy !== 1'b0) $display("FAIL conflict_cleared: got %0b want 0", chk_rs1_busy); else n_pass++;
    $display("rd0_conflict: done");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  q_rd [$];
    logic [31:0] q_data [$];
    logic [4:0]  acc_rd [$];
    logic [31:0] acc_data [$];
    logic        exp_rdy, exp_w;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    int          accepted = 0;
    int          dut_writes = 0;
    for (int c = 0; c < 26; c++) begin
      acc_rd.delete(); acc_data.delete();
      exp_rdy = ((4 - q_rd.size()) >= 2);
      if (c < 20) begin
        mem_valid = 1'b1; mem_rd = 5'(1 + (c * 3) % 31); mem_data = 32'h1000_0000 + 32'(c * 256 + 1);
        alu_valid = 1'b1; alu_rd = 5'(1 + (c * 7 + 5) % 31); alu_data = 32'h2000_0000 + 32'(c * 256 + 2);
        n_checks++; if (alu_ready !== exp_rdy || mem_ready !== exp_rdy)
          $display("FAIL b2b_ready: cycle %0d got %0b%0b want %0b", c, alu_ready, mem_ready, exp_rdy); else n_pass++;
        if (exp_rdy) begin
          acc_rd.push_back(mem_rd); acc_data.push_back(mem_data);
          acc_rd.push_back(alu_rd); acc_data.push_back(alu_data);
          accepted += 2;
        end
      end else begin
        idle();
      end
      tick();
      exp_w = 1'b0; exp_a = '0; exp_d = '0;
      if (q_rd.size() != 0) begin
        exp_w = 1'b1; exp_a = q_rd.pop_front(); exp_d = q_data.pop_front();
      end else if (acc_rd.size() != 0) begin
        exp_w = 1'b1; exp_a = acc_rd.pop_front(); exp_d = acc_data.pop_front();
      end
      foreach (acc_rd[i]) begin
        q_rd.push_back(acc_rd[i]); q_data.push_back(acc_data[i]);
      end
      if (rf_write === 1'b1) dut_writes++;
      n_checks++; if (rf_write !== exp_w || (exp_w && (rf_addr !== exp_a || rf_data !== exp_d)))
        $display("FAIL b2b_write: cycle %0d got w=%0b a=%0d d=%h want w=%0b a=%0d d=%h", c, rf_write, rf_addr, rf_data, exp_w, exp_a, exp_d); else n_pass++;
      n_checks++; if (wb_count !== 3'(q_rd.size()))
        $display("FAIL b2b_count: cycle %0d got %0d want %0d", c, wb_count, q_rd.size()); else n_pass++;
    end
    idle();
    n_checks++; if (dut_writes != accepted) $display("FAIL b2b_total: got %0d writes want %0d", dut_writes, accepted); else n_pass++;
    n_checks++; if (wb_error !== 1'b0) $display("FAIL err_before: got %0b want 0", wb_error); else n_pass++;
    rf_addr_error = 1'b1;
    tick();
    rf_addr_error = 1'b0;
    n_checks++; if (wb_error !== 1'b1) $display("FAIL err_set: got %0b want 1", wb_error); else n_pass++;
    tick();
    n_checks++; if (wb_error !== 1'b1) $display("FAIL err_sticky: got %0b want 1", wb_error); else n_pass++;
    $display("back_to_back: accepted %0d written %0d", accepted, dut_writes);
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_single_alu();
    test_dual();
    test_scoreboard();
    test_rd0_conflict();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
